// File: rtl/mult8b_ctrl_pkg.sv
// Shared types and constants for the 8x8 nibble-split multiplier sequencer:
// state encoding, control-word layout and the per-step control table.
package mult8b_ctrl_pkg;

    localparam int unsigned N_STEPS = 10;
    localparam logic        OP_ADD  = 1'b0;
    localparam logic        OP_SUB  = ~OP_ADD;

    // REG1 source select
    localparam logic [2:0] R1SEL_OPERANDS = 3'd0;
    localparam logic [2:0] R1SEL_ROM_LO   = 3'd1;
    localparam logic [2:0] R1SEL_ROM_HI   = 3'd2;
    localparam logic [2:0] R1SEL_SUM      = 3'd3;

    // addsub operand pair select
    localparam logic [2:0] ASSEL_A_NIBS = 3'd0;
    localparam logic [2:0] ASSEL_B_NIBS = 3'd1;
    localparam logic [2:0] ASSEL_PH_PL  = 3'd2;
    localparam logic [2:0] ASSEL_MIDDLE = 3'd4;
    localparam logic [2:0] ASSEL_FINAL  = 3'd5;

    // ROM factor select
    localparam logic [1:0] ROMSEL_SUMS = 2'd0;
    localparam logic [1:0] ROMSEL_LO   = 2'd1;
    localparam logic [1:0] ROMSEL_HI   = 2'd2;

    typedef enum logic [3:0] {
        StIdle = 4'd0,
        St1    = 4'd1,
        St2    = 4'd2,
        St3    = 4'd3,
        St4    = 4'd4,
        St5    = 4'd5,
        St6    = 4'd6,
        St7    = 4'd7,
        St8    = 4'd8,
        St9    = 4'd9,
        St10   = 4'd10,
        StFin  = 4'd11
    } state_e;

    typedef struct packed {
        logic       ld1;
        logic       ld2;
        logic       ldres;
        logic       op;
        logic [2:0] r1sel;
        logic [2:0] assel;
        logic [1:0] romsel;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = '{
        1'b0, 1'b0, 1'b0, OP_ADD, R1SEL_OPERANDS, ASSEL_A_NIBS, ROMSEL_SUMS
    };

    // Field order: ld1, ld2, ldres, op, r1sel, assel, romsel
    localparam ctrl_word_t CTRL_TABLE [N_STEPS] = '{
        '{1'b1, 1'b0, 1'b0, OP_ADD, R1SEL_OPERANDS, ASSEL_A_NIBS, ROMSEL_SUMS},
        '{1'b0, 1'b0, 1'b0, OP_ADD, R1SEL_OPERANDS, ASSEL_A_NIBS, ROMSEL_SUMS},
        '{1'b0, 1'b0, 1'b1, OP_ADD, R1SEL_OPERANDS, ASSEL_B_NIBS, ROMSEL_SUMS},
        '{1'b0, 1'b1, 1'b0, OP_ADD, R1SEL_OPERANDS, ASSEL_A_NIBS, ROMSEL_SUMS},
        '{1'b1, 1'b0, 1'b0, OP_ADD, R1SEL_ROM_LO,   ASSEL_A_NIBS, ROMSEL_LO},
        '{1'b1, 1'b0, 1'b0, OP_ADD, R1SEL_ROM_HI,   ASSEL_A_NIBS, ROMSEL_HI},
        '{1'b0, 1'b0, 1'b0, OP_ADD, R1SEL_OPERANDS, ASSEL_PH_PL,  ROMSEL_SUMS},
        '{1'b0, 1'b0, 1'b1, OP_SUB, R1SEL_OPERANDS, ASSEL_MIDDLE, ROMSEL_SUMS},
        '{1'b1, 1'b0, 1'b0, OP_ADD, R1SEL_SUM,      ASSEL_FINAL,  ROMSEL_SUMS},
        '{1'b0, 1'b0, 1'b1, OP_ADD, R1SEL_OPERANDS, ASSEL_FINAL,  ROMSEL_SUMS}
    };

    // Step index shown on STEP: 1..10 while sequencing, 0 in IDLE/FIN.
    function automatic logic [3:0] step_of(input state_e s);
        return (s >= St1 && s <= St10) ? 4'(s) : 4'd0;
    endfunction

endpackage

// File: rtl/ctrl_step_rom.sv
// Combinational lookup from step index to control word; step 0 (or any
// out-of-range index) yields the idle word.
module ctrl_step_rom
    import mult8b_ctrl_pkg::*;
(
    input  logic [3:0] step_i,
    output ctrl_word_t ctrl_o
);

    logic [3:0] idx;

    always_comb begin
        idx    = step_i - 4'd1;
        ctrl_o = CTRL_IDLE;
        if (step_i >= 4'd1 && step_i <= 4'(N_STEPS)) begin
            ctrl_o = CTRL_TABLE[idx];
        end
    end

endmodule

// File: rtl/controle_mult8b.sv
// Sequencer for the nibble-split 8x8 multiplier: walks the control table once per
// START and holds DONE until the next START or reset.
module controle_mult8b
    import mult8b_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    output logic       DONE,
    output logic       BUSY,
    output logic       LOAD_REG1,
    output logic       LOAD_REG2,
    output logic       LOAD_RES,
    output logic       OP,
    output logic [2:0] MUX_CONTROL_LOAD_REG1,
    output logic [2:0] MUX_CONTROL_SUM_SUB,
    output logic [1:0] MUX_CONTROL_ROM,
    output logic [3:0] STEP
);

    state_e     state_d, state_q;
    ctrl_word_t ctrl_d, ctrl_q;
    logic [3:0] step_d, step_q;
    logic       busy_d, busy_q;
    logic       done_d, done_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StFin: begin
                if (START) begin
                    state_d = St1;
                end
            end
            St1, St2, St3, St4, St5, St6, St7, St8, St9: begin
                state_d = state_e'(state_q + 4'd1);
            end
            St10:    state_d = StFin;
            default: state_d = StIdle;
        endcase

        // Outputs are computed from the next state so they line up with STEP.
        step_d = step_of(state_d);
        busy_d = (step_d != 4'd0);
        done_d = (state_d == StFin);
    end

    ctrl_step_rom u_step_rom (
        .step_i (step_d),
        .ctrl_o (ctrl_d)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StIdle;
            ctrl_q  <= CTRL_IDLE;
            step_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        DONE                  = done_q;
        BUSY                  = busy_q;
        STEP                  = step_q;
        LOAD_REG1             = ctrl_q.ld1;
        LOAD_REG2             = ctrl_q.ld2;
        LOAD_RES              = ctrl_q.ldres;
        OP                    = ctrl_q.op;
        MUX_CONTROL_LOAD_REG1 = ctrl_q.r1sel;
        MUX_CONTROL_SUM_SUB   = ctrl_q.assel;
        MUX_CONTROL_ROM       = ctrl_q.romsel;
    end

endmodule

// File: tb/tb_controle_mult8b.sv
// Bench for controle_mult8b: a cycle-level sequence model checks every output each
// cycle, and a behavioural datapath driven by the DUT checks the final product.
module tb_controle_mult8b;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic       DONE, BUSY, LOAD_REG1, LOAD_REG2, LOAD_RES, OP;
    logic [2:0] MUX_CONTROL_LOAD_REG1, MUX_CONTROL_SUM_SUB;
    logic [1:0] MUX_CONTROL_ROM;
    logic [3:0] STEP;

    controle_mult8b dut (
        .CLK                   (CLK),
        .RST_N                 (RST_N),
        .START                 (START),
        .DONE                  (DONE),
        .BUSY                  (BUSY),
        .LOAD_REG1             (LOAD_REG1),
        .LOAD_REG2             (LOAD_REG2),
        .LOAD_RES              (LOAD_RES),
        .OP                    (OP),
        .MUX_CONTROL_LOAD_REG1 (MUX_CONTROL_LOAD_REG1),
        .MUX_CONTROL_SUM_SUB   (MUX_CONTROL_SUM_SUB),
        .MUX_CONTROL_ROM       (MUX_CONTROL_ROM),
        .STEP                  (STEP)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Sequence model: 0 = idle, 1..10 = step, 11 = finished.
    int model_pos = 0;

    function automatic logic [12:0] cw(input logic ld1, input logic ld2, input logic ldres,
                                       input logic op, input int r1, input int as,
                                       input int rom);
        return {ld1, ld2, ldres, op, 3'(r1), 3'(as), 2'(rom)};
    endfunction

    // Expected control word per step, written straight from the control table.
    function automatic logic [12:0] exp_ctrl(input int pos);
        case (pos)
            1:       return cw(1, 0, 0, 0, 0, 0, 0);
            2:       return cw(0, 0, 0, 0, 0, 0, 0);
            3:       return cw(0, 0, 1, 0, 0, 1, 0);
            4:       return cw(0, 1, 0, 0, 0, 0, 0);
            5:       return cw(1, 0, 0, 0, 1, 0, 1);
            6:       return cw(1, 0, 0, 0, 2, 0, 2);
            7:       return cw(0, 0, 0, 0, 0, 2, 0);
            8:       return cw(0, 0, 1, 1, 0, 4, 0);
            9:       return cw(1, 0, 0, 0, 3, 5, 0);
            10:      return cw(0, 0, 1, 0, 0, 5, 0);
            default: return 13'd0;
        endcase
    endfunction

    // Behavioural datapath: REG1={Al,Bl,Ah,Bh}, registered addsub output in dp_sum.
    logic [7:0]  op_a = 8'd0, op_b = 8'd0;
    logic [15:0] dp_reg1 = '0, dp_reg2 = '0, dp_res = '0, dp_sum = '0;
    logic [15:0] n3, n2, n1, n0, rom_out, as_out, r1_mux, pl_ph;

    always_comb begin
        n3    = {12'd0, dp_reg1[15:12]};
        n2    = {12'd0, dp_reg1[11:8]};
        n1    = {12'd0, dp_reg1[7:4]};
        n0    = {12'd0, dp_reg1[3:0]};
        pl_ph = {8'd0, dp_reg1[15:8]} + {8'd0, dp_reg1[7:0]};
        case (MUX_CONTROL_ROM)
            2'd0:    rom_out = dp_res * dp_sum;
            2'd1:    rom_out = n3 * n2;
            2'd2:    rom_out = n1 * n0;
            default: rom_out = 16'd0;
        endcase
        case (MUX_CONTROL_SUM_SUB)
            3'd0:    as_out = n3 + n1;
            3'd1:    as_out = n2 + n0;
            3'd2:    as_out = {dp_reg1[7:0], dp_reg1[15:8]};
            3'd4:    as_out = OP ? dp_reg2 - pl_ph : dp_reg2 + pl_ph;
            3'd5:    as_out = dp_res + (dp_sum << 4);
            default: as_out = 16'd0;
        endcase
        case (MUX_CONTROL_LOAD_REG1)
            3'd0:    r1_mux = {op_a[3:0], op_b[3:0], op_a[7:4], op_b[7:4]};
            3'd1:    r1_mux = {rom_out[7:0], dp_reg1[7:0]};
            3'd2:    r1_mux = {dp_reg1[15:8], rom_out[7:0]};
            3'd3:    r1_mux = dp_sum;
            default: r1_mux = dp_reg1;
        endcase
    end

    always_ff @(posedge CLK) begin
        dp_sum <= as_out;
        if (LOAD_REG1) dp_reg1 <= r1_mux;
        if (LOAD_REG2) dp_reg2 <= rom_out;
        if (LOAD_RES)  dp_res  <= dp_sum;
    end

    // One clock with the given inputs, then every output is checked against the model.
    task automatic cycle(input logic start, input logic rst_n);
        logic [12:0] got_ctrl;
        int          exp_step;
        START = start;
        RST_N = rst_n;
        @(posedge CLK);
        #1;
        if (!rst_n)                               model_pos = 0;
        else if (model_pos == 0 || model_pos == 11) model_pos = start ? 1 : model_pos;
        else                                      model_pos = model_pos + 1;
        exp_step = (model_pos >= 1 && model_pos <= 10) ? model_pos : 0;
        got_ctrl = {LOAD_REG1, LOAD_REG2, LOAD_RES, OP, MUX_CONTROL_LOAD_REG1,
                    MUX_CONTROL_SUM_SUB, MUX_CONTROL_ROM};
        check_val("step", 32'(STEP), 32'(exp_step));
        check_val("busy", 32'(BUSY), 32'(exp_step != 0));
        check_val("done", 32'(DONE), 32'(model_pos == 11));
        check_val("ctrl", 32'(got_ctrl), 32'(exp_ctrl(model_pos)));
        check_val("legal_sel", 32'(MUX_CONTROL_ROM != 2'd3 && MUX_CONTROL_SUM_SUB < 3'd6), 32'd1);
    endtask

    task automatic run_mult(input logic [7:0] a, input logic [7:0] b);
        op_a = a;
        op_b = b;
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 20 && !DONE; i++) cycle(1'b0, 1'b1);
        check_val("done_seen", 32'(DONE), 32'd1);
        check_val("product", 32'(dp_res), 32'(a) * 32'(b));
    endtask

    initial begin
        // Reset with START high
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);

        // Single run with a one-cycle START, then DONE held
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 13; i++) cycle(1'b0, 1'b1);

        // START held throughout: no restart mid-sequence, restart from FIN
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1);
        check_val("restart_from_fin", 32'(STEP), 32'd1);
        for (int i = 0; i < 11; i++) cycle(1'b0, 1'b1);

        // Reset in S6, then a clean run
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
        check_val("at_s6", 32'(STEP), 32'd6);
        cycle(1'b0, 1'b0);
        check_val("mid_reset_ld1", 32'(LOAD_REG1), 32'd0);
        cycle(1'b0, 1'b1);

        // Integration with the datapath
        run_mult(8'd200, 8'd150);
        run_mult(8'hFF, 8'hFF);
        run_mult(8'd0, 8'd77);
        for (int i = 0; i < 12; i++) run_mult(8'($urandom), 8'($urandom));

        // Random START/RST_N traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) == 0, ($urandom % 40) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
